// File: rtl/kernel_bank_fetch_unit.sv
// Kernel bank fetch unit: streams num_ch*ker_size*ker_size consecutive words
// out of a BRAM and assembles them into a [ch][row][col] kernel bank. The
// bank is held stable until the consumer accepts it.
module kernel_bank_fetch_unit #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_KERNEL_SIZE = 5,
  parameter int NUM_CH          = 4,
  parameter int BRAM_LATENCY    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   continue_mode,
  input  logic [ADDR_WIDTH-1:0]                  base_addr,
  input  logic [2:0]                             ker_size,
  input  logic [$clog2(NUM_CH+1)-1:0]            num_ch,
  output logic                                   bram_en,
  output logic [ADDR_WIDTH-1:0]                  bram_addr,
  input  logic [DATA_WIDTH-1:0]                  bram_din,
  output logic [NUM_CH-1:0][MAX_KERNEL_SIZE-1:0][MAX_KERNEL_SIZE-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                   data_out_valid,
  input  logic                                   data_out_ready,
  output logic                                   busy,
  output logic                                   cfg_err
);

  localparam int KW  = 3;
  localparam int NCW = $clog2(NUM_CH + 1);
  localparam int RW  = (MAX_KERNEL_SIZE > 1) ? $clog2(MAX_KERNEL_SIZE) : 1;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [KW-1:0]  KMAX  = KW'(MAX_KERNEL_SIZE);
  localparam logic [NCW-1:0] NCMAX = NCW'(NUM_CH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            state;
  logic [KW-1:0]         ks_q;
  logic [NCW-1:0]        nc_q;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Position of the word currently being issued
  logic [KW-1:0]         icol;
  logic [KW-1:0]         irow;
  logic [NCW-1:0]        ich;

  logic cfg_ok;
  logic col_end;
  logic row_end;
  logic issue_last;

  // Capture pipeline: one entry per BRAM latency cycle
  logic          p_vld  [BRAM_LATENCY];
  logic          p_last [BRAM_LATENCY];
  logic [CW-1:0] p_ch   [BRAM_LATENCY];
  logic [RW-1:0] p_row  [BRAM_LATENCY];
  logic [RW-1:0] p_col  [BRAM_LATENCY];

  assign cfg_ok = (ker_size != '0) && (ker_size <= KMAX) &&
                  (num_ch != '0) && (num_ch <= NCMAX);

  assign col_end    = (icol == ks_q - KW'(1));
  assign row_end    = (irow == ks_q - KW'(1));
  assign issue_last = col_end && row_end && (ich == nc_q - NCW'(1));

  assign busy           = (state != S_IDLE);
  assign data_out_valid = (state == S_HOLD);

  // Control FSM, address generation and bank capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      next_addr <= '0;
      cfg_err   <= 1'b0;
      data_out  <= '0;
      ks_q      <= '0;
      nc_q      <= '0;
      icol      <= '0;
      irow      <= '0;
      ich       <= '0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              ks_q      <= ker_size;
              nc_q      <= num_ch;
              data_out  <= '0;
              bram_addr <= continue_mode ? next_addr : base_addr;
              bram_en   <= 1'b1;
              icol      <= '0;
              irow      <= '0;
              ich       <= '0;
              state     <= S_FETCH;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue_last) begin
            bram_en   <= 1'b0;
            next_addr <= bram_addr + ADDR_WIDTH'(1);
            state     <= S_DRAIN;
          end else begin
            bram_addr <= bram_addr + ADDR_WIDTH'(1);
            if (col_end) begin
              icol <= '0;
              if (row_end) begin
                irow <= '0;
                ich  <= ich + NCW'(1);
              end else begin
                irow <= irow + KW'(1);
              end
            end else begin
              icol <= icol + KW'(1);
            end
          end
        end
        S_DRAIN: begin
        end
        default: begin
          if (data_out_ready) state <= S_IDLE;
        end
      endcase

      if (p_vld[BRAM_LATENCY-1]) begin
        data_out[p_ch[BRAM_LATENCY-1]][p_row[BRAM_LATENCY-1]][p_col[BRAM_LATENCY-1]] <= bram_din;
        if (p_last[BRAM_LATENCY-1] && (state == S_DRAIN)) state <= S_HOLD;
      end
    end
  end

  // Delay issue valid/position by the BRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BRAM_LATENCY; i++) begin
        p_vld[i]  <= 1'b0;
        p_last[i] <= 1'b0;
        p_ch[i]   <= '0;
        p_row[i]  <= '0;
        p_col[i]  <= '0;
      end
    end else begin
      p_vld[0]  <= bram_en;
      p_last[0] <= bram_en && issue_last;
      p_ch[0]   <= CW'(ich);
      p_row[0]  <= RW'(irow);
      p_col[0]  <= RW'(icol);
      for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_last[i] <= p_last[i-1];
        p_ch[i]   <= p_ch[i-1];
        p_row[i]  <= p_row[i-1];
        p_col[i]  <= p_col[i-1];
      end
    end
  end

endmodule

// File: tb/tb_kernel_bank_fetch_unit.sv
// Directed bench for kernel_bank_fetch_unit: one instance at BRAM latency 1,
// one at latency 3, each fed by a BRAM model where mem[a] = a.
module tb_kernel_bank_fetch_unit;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int MK  = 5;
  localparam int NC  = 4;
  localparam int NCW = $clog2(NC + 1);

  typedef logic [NC-1:0][MK-1:0][MK-1:0][DW-1:0] bank_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, start_a, cm_a, rdy_a;
  logic [AW-1:0]  base_a;
  logic [2:0]     ks_a;
  logic [NCW-1:0] nc_a;
  logic           en_a, vld_a, busy_a, err_a;
  logic [AW-1:0]  addr_a;
  logic [DW-1:0]  din_a;
  bank_t          dout_a;

  logic           rst_b, start_b, cm_b, rdy_b;
  logic [AW-1:0]  base_b;
  logic [2:0]     ks_b;
  logic [NCW-1:0] nc_b;
  logic           en_b, vld_b, busy_b, err_b;
  logic [AW-1:0]  addr_b;
  logic [DW-1:0]  din_b;
  bank_t          dout_b;

  // BRAM models returning the address as data after 1 and 3 cycles
  logic [AW-1:0] sra;
  logic [AW-1:0] srb [3];
  always @(posedge clk) begin
    sra    <= addr_a;
    srb[0] <= addr_b;
    srb[1] <= srb[0];
    srb[2] <= srb[1];
  end
  assign din_a = {{(DW-AW){1'b0}}, sra};
  assign din_b = {{(DW-AW){1'b0}}, srb[2]};

  kernel_bank_fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_KERNEL_SIZE(MK), .NUM_CH(NC), .BRAM_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .continue_mode(cm_a), .base_addr(base_a),
    .ker_size(ks_a), .num_ch(nc_a), .bram_en(en_a), .bram_addr(addr_a), .bram_din(din_a),
    .data_out(dout_a), .data_out_valid(vld_a), .data_out_ready(rdy_a), .busy(busy_a),
    .cfg_err(err_a)
  );

  kernel_bank_fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_KERNEL_SIZE(MK), .NUM_CH(NC), .BRAM_LATENCY(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .continue_mode(cm_b), .base_addr(base_b),
    .ker_size(ks_b), .num_ch(nc_b), .bram_en(en_b), .bram_addr(addr_b), .bram_din(din_b),
    .data_out(dout_b), .data_out_valid(vld_b), .data_out_ready(rdy_b), .busy(busy_b),
    .cfg_err(err_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] wrap_exp [4];
  logic [2:0]    ks_bad   [3];
  logic [NCW-1:0] nc_bad  [3];

  initial begin
    wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    ks_bad   = '{3'd0, 3'd6, 3'd3};
    nc_bad   = '{3'd1, 3'd1, 3'd0};

    rst_a = 1'b1; start_a = 1'b0; cm_a = 1'b0; rdy_a = 1'b0; base_a = '0; ks_a = '0; nc_a = '0;
    rst_b = 1'b1; start_b = 1'b0; cm_b = 1'b0; rdy_b = 1'b0; base_b = '0; ks_b = '0; nc_b = '0;
    tick;
    tick;
    chk("rst_a_en",   64'(en_a),   64'(0));
    chk("rst_a_addr", 64'(addr_a), 64'(0));
    chk("rst_a_vld",  64'(vld_a),  64'(0));
    chk("rst_a_busy", 64'(busy_a), 64'(0));
    chk("rst_a_err",  64'(err_a),  64'(0));
    chk("rst_a_bank_nonzero", 64'(dout_a != '0), 64'(0));
    chk("rst_b_en",   64'(en_b),   64'(0));
    chk("rst_b_busy", 64'(busy_b), 64'(0));
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick;

    // Basic fetch: 3x3 kernel, 2 channels from 0x010
    base_a = 10'h010; ks_a = 3'd3; nc_a = 3'd2; cm_a = 1'b0; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("a_fetch_en",   64'(en_a),   64'(1));
      chk("a_fetch_addr", 64'(addr_a), 64'(10'h010 + i));
      chk("a_fetch_busy", 64'(busy_a), 64'(1));
      chk("a_fetch_vld",  64'(vld_a),  64'(0));
      tick;
    end
    chk("a_c19_en",   64'(en_a),   64'(0));
    chk("a_c19_addr", 64'(addr_a), 64'(10'h021));
    chk("a_c19_vld",  64'(vld_a),  64'(0));
    tick;
    chk("a_c20_vld", 64'(vld_a), 64'(1));
    for (int ch = 0; ch < NC; ch++)
      for (int r = 0; r < MK; r++)
        for (int c = 0; c < MK; c++)
          chk($sformatf("a_bank[%0d][%0d][%0d]", ch, r, c), 64'(dout_a[2'(ch)][3'(r)][3'(c)]),
              (ch < 2 && r < 3 && c < 3) ? 64'(16 + ch*9 + r*3 + c) : 64'(0));

    // Hold with ready low while start toggles
    for (int i = 0; i < 10; i++) begin
      start_a = (i % 2 == 0); base_a = 10'h200;
      chk("hold_vld",  64'(vld_a),  64'(1));
      chk("hold_busy", 64'(busy_a), 64'(1));
      chk("hold_en",   64'(en_a),   64'(0));
      chk("hold_err",  64'(err_a),  64'(0));
      chk("hold_d122", 64'(dout_a[1][2][2]), 64'(32'h021));
      chk("hold_d000", 64'(dout_a[0][0][0]), 64'(32'h010));
      tick;
    end
    start_a = 1'b1; rdy_a = 1'b1;
    chk("accept_cycle_vld", 64'(vld_a), 64'(1));
    tick;
    start_a = 1'b0; rdy_a = 1'b0;
    chk("post_accept_vld",  64'(vld_a),  64'(0));
    chk("post_accept_busy", 64'(busy_a), 64'(0));
    chk("post_accept_en",   64'(en_a),   64'(0));
    chk("idle_keep_d122",   64'(dout_a[1][2][2]), 64'(32'h021));
    tick;
    chk("start_in_accept_ignored", 64'(busy_a), 64'(0));

    // Continue from stored next address
    cm_a = 1'b1; base_a = 10'h300; ks_a = 3'd2; nc_a = 3'd1; start_a = 1'b1;
    tick;
    start_a = 1'b0; cm_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("cont_addr", 64'(addr_a), 64'(10'h022 + i));
      chk("cont_en",   64'(en_a),   64'(1));
      tick;
    end
    chk("cont_c5_vld", 64'(vld_a), 64'(0));
    tick;
    chk("cont_c6_vld", 64'(vld_a), 64'(1));
    chk("cont_d000", 64'(dout_a[0][0][0]), 64'(32'h022));
    chk("cont_d001", 64'(dout_a[0][0][1]), 64'(32'h023));
    chk("cont_d010", 64'(dout_a[0][1][0]), 64'(32'h024));
    chk("cont_d011", 64'(dout_a[0][1][1]), 64'(32'h025));
    chk("cont_d022_zeroed", 64'(dout_a[0][2][2]), 64'(0));
    chk("cont_d122_zeroed", 64'(dout_a[1][2][2]), 64'(0));
    rdy_a = 1'b1;
    tick;
    rdy_a = 1'b0;

    // Address wrap at the top of the BRAM
    base_a = 10'h3FE; ks_a = 3'd2; nc_a = 3'd1; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", 64'(addr_a), 64'(wrap_exp[i]));
      tick;
    end
    tick;
    chk("wrap_vld",  64'(vld_a), 64'(1));
    chk("wrap_d001", 64'(dout_a[0][0][1]), 64'(32'h3FF));
    chk("wrap_d010", 64'(dout_a[0][1][0]), 64'(0));
    chk("wrap_d011", 64'(dout_a[0][1][1]), 64'(1));
    rdy_a = 1'b1;
    tick;
    rdy_a = 1'b0;
    cm_a = 1'b1; ks_a = 3'd1; nc_a = 3'd1; start_a = 1'b1;
    tick;
    start_a = 1'b0; cm_a = 1'b0;
    chk("next_after_wrap_addr", 64'(addr_a), 64'(10'h002));
    chk("next_after_wrap_en",   64'(en_a),   64'(1));
    tick;
    chk("k1_c2_en", 64'(en_a), 64'(0));
    tick;
    chk("k1_c3_vld",  64'(vld_a), 64'(1));
    chk("k1_d000",    64'(dout_a[0][0][0]), 64'(2));
    rdy_a = 1'b1;
    tick;
    rdy_a = 1'b0;

    // Rejected configurations
    for (int k = 0; k < 3; k++) begin
      ks_a = ks_bad[k]; nc_a = nc_bad[k]; start_a = 1'b1;
      tick;
      start_a = 1'b0;
      chk($sformatf("bad%0d_err", k),  64'(err_a),  64'(1));
      chk($sformatf("bad%0d_en", k),   64'(en_a),   64'(0));
      chk($sformatf("bad%0d_busy", k), 64'(busy_a), 64'(0));
      tick;
      chk($sformatf("bad%0d_err_clear", k), 64'(err_a), 64'(0));
      chk($sformatf("bad%0d_busy2", k),     64'(busy_a), 64'(0));
      chk($sformatf("bad%0d_keep", k),      64'(dout_a[0][0][0]), 64'(2));
    end

    // Largest legal bank: 5x5 kernel, 4 channels
    base_a = 10'h100; ks_a = 3'd5; nc_a = 3'd4; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("max_err", 64'(err_a), 64'(0));
    for (int i = 0; i < 100; i++) begin
      chk("max_addr", 64'(addr_a), 64'(10'h100 + i));
      tick;
    end
    chk("max_c101_vld", 64'(vld_a), 64'(0));
    tick;
    chk("max_c102_vld", 64'(vld_a), 64'(1));
    chk("max_d000", 64'(dout_a[0][0][0]), 64'(32'h100));
    chk("max_d213", 64'(dout_a[2][1][3]), 64'(32'h13A));
    chk("max_d344", 64'(dout_a[3][4][4]), 64'(32'h163));

    // Reset wins over start and ready in HOLD
    rst_a = 1'b1; rdy_a = 1'b1; start_a = 1'b1; base_a = 10'h050; ks_a = 3'd1; nc_a = 3'd1;
    tick;
    rst_a = 1'b0; rdy_a = 1'b0; start_a = 1'b0;
    chk("rstpri_busy", 64'(busy_a), 64'(0));
    chk("rstpri_en",   64'(en_a),   64'(0));
    chk("rstpri_addr", 64'(addr_a), 64'(0));
    chk("rstpri_bank_nonzero", 64'(dout_a != '0), 64'(0));

    // Latency 3: reset in the middle of a fetch
    base_b = 10'h040; ks_b = 3'd3; nc_b = 3'd2; start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b_addr", 64'(addr_b), 64'(10'h040 + i));
      chk("b_en",   64'(en_b),   64'(1));
      if (i == 3) rst_b = 1'b1;
      tick;
    end
    rst_b = 1'b0;
    chk("b_rst_en",   64'(en_b),   64'(0));
    chk("b_rst_addr", 64'(addr_b), 64'(0));
    chk("b_rst_vld",  64'(vld_b),  64'(0));
    chk("b_rst_busy", 64'(busy_b), 64'(0));
    chk("b_rst_err",  64'(err_b),  64'(0));
    chk("b_rst_bank_nonzero", 64'(dout_b != '0), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("b_no_stale_bank_nonzero", 64'(dout_b != '0), 64'(0));
      chk("b_idle_en", 64'(en_b), 64'(0));
    end

    base_b = 10'h080; ks_b = 3'd2; nc_b = 3'd2; start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b2_addr", 64'(addr_b), 64'(10'h080 + i));
      tick;
    end
    chk("b2_c9_en", 64'(en_b), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk("b2_vld_early", 64'(vld_b), 64'(0));
      tick;
    end
    chk("b2_c12_vld", 64'(vld_b), 64'(1));
    for (int ch = 0; ch < NC; ch++)
      for (int r = 0; r < MK; r++)
        for (int c = 0; c < MK; c++)
          chk($sformatf("b2_bank[%0d][%0d][%0d]", ch, r, c), 64'(dout_b[2'(ch)][3'(r)][3'(c)]),
              (ch < 2 && r < 2 && c < 2) ? 64'(32'h080 + ch*4 + r*2 + c) : 64'(0));
    rdy_b = 1'b1;
    tick;
    rdy_b = 1'b0;
    chk("b2_release_busy", 64'(busy_b), 64'(0));
    chk("b2_release_vld",  64'(vld_b),  64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
